avalon_onchip_ram_ctrl: RTL and testbench
=========================================

Name: avalon_onchip_ram_ctrl

Overview:
- Parametrised Avalon-MM on-chip RAM slave: the next generation of the fixed 32-bit x 30720-word single-port RAM wrapper.
- Adds configurable width, depth and read latency.
- Adds pipelined reads with readdatavalid, and waitrequest-based flow control.
- Adds optional memory clear after reset, and out-of-range access detection.
- Sits on the system interconnect as the processor's main program/data memory; it uses an inferred RAM array with no vendor megafunction.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 15, word-address width.
- DEPTH, 30720, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, when 1, fill every word with CLEAR_VALUE after reset release.
- CLEAR_VALUE, 0, fill pattern, DATA_WIDTH bits.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  DATA_WIDTH/8  write byte lanes.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_WIDTH  write data.
- clken  in  1  global clock enable; 0 stalls the block.
- readdata  out  DATA_WIDTH  read data.
- readdatavalid  out  1  readdata qualifier.
- waitrequest  out  1  slave not accepting.
- init_done  out  1  clear complete, memory usable.
- oob_error  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: readdata=0, readdatavalid=0, waitrequest=1, init_done=0, oob_error=0.
  - Read pipeline is flushed; FSM goes to CLEAR (if CLEAR_ON_RESET=1) or READY (if 0).
  - RAM contents are not reset.
- FSM CLEAR:
  - Clear counter starts at 0.
  - Each cycle with clken=1: write CLEAR_VALUE to mem[counter], then counter++.
  - When the write to DEPTH-1 completes, go to READY next cycle.
  - While in CLEAR: waitrequest=1 and init_done=0; bus requests are ignored.
  - Reset asserted mid-clear restarts the clear from address 0.
- FSM READY:
  - init_done=1.
  - Stays in READY until reset.
- waitrequest = (state != READY) | ~clken, driven combinationally from the FSM state register and clken.
- Acceptance: a request is accepted on a clk edge when chipselect=1, waitrequest=0 and (read=1 or write=1).
- Write:
  - Only byte lanes with byteenable[i]=1 are updated; other bytes keep their old value.
  - Write is committed on the acceptance edge.
  - No readdatavalid is produced.
- Read:
  - readdatavalid pulses high exactly READ_LATENCY clk cycles (with clken=1) after the acceptance edge.
  - readdata carries mem[address] as of the acceptance edge.
  - One read can be accepted per cycle; back-to-back reads give back-to-back readdatavalid.
- read=1 and write=1 together: the write is performed and the read is discarded (no readdatavalid).
- Write followed by read of the same address on the next cycle returns the new data.
- clken=0:
  - RAM, pipeline registers, FSM and clear counter all freeze.
  - readdatavalid and readdata hold their values; a pulse that is already valid is extended until clken returns.
- readdata holds its last value while readdatavalid=0.
- Out-of-range access (address >= DEPTH), when accepted:
  - Write is dropped.
  - Read returns 0 with normal readdatavalid timing.
  - oob_error is set and stays set until reset.
- READ_LATENCY=2 adds one output register stage after the RAM read register.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5A5A5A5, release reset_n -> waitrequest=1 for 16 clocks, then init_done=1 and waitrequest=0; read addr 9 returns 0xA5A5A5A5.
- Write 0x11223344 to addr 3 (byteenable=4'hF), then write 0xDEADBEEF with byteenable=4'b0101, then read addr 3 -> readdata=0x11AD33EF; readdatavalid 1 cycle after acceptance at READ_LATENCY=1, 2 cycles at READ_LATENCY=2.
- READ_LATENCY=2, addrs 0..3 pre-written with 0..3, reads issued on 4 consecutive cycles -> readdatavalid high 4 consecutive cycles, starting 2 cycles after the first read, with data 0,1,2,3 in order.
- Read accepted, clken dropped for 3 cycles before data returns -> waitrequest=1 during the stall; readdatavalid appears only after clken=1, with correct data and no duplicate or lost pulse.
- DEPTH=16, write 0xFFFFFFFF to addr 20, then read addr 20 -> oob_error=1 and the read returns 0; a following read of addr 4 is unchanged; oob_error stays 1 until reset_n is pulsed.
- reset_n pulsed low when the clear counter is at 7 -> all outputs take their reset values immediately without a clock; after release, the clear restarts at 0 and takes the full 16 cycles; init_done rises only afterwards.

Source files
------------

// File: rtl/avalon_onchip_ram_ctrl.sv
// Avalon-MM on-chip RAM slave with configurable width, depth and read latency.
// Supports byte-enabled writes, pipelined reads with readdatavalid, a global clock
// enable, an optional post-reset memory clear, and a sticky out-of-range flag.
module avalon_onchip_ram_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 15,
  parameter int unsigned           DEPTH          = 30720,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done,
  output logic                    oob_error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  clr_cnt;
  logic [IDX_W-1:0]  clr_cnt_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  accept;
  logic                  acc_rd;
  logic                  acc_wr;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // Address decode; the array index only carries the bits needed for DEPTH.
  assign in_range = 32'(address) < 32'(DEPTH);
  assign idx      = IDX_W'(address);

  // Flow control straight from the state register; also held off while in reset.
  assign waitrequest = ~reset_n | (state != ST_READY) | ~clken;

  // Simultaneous read+write performs the write and drops the read.
  assign accept = chipselect & ~waitrequest & (read | write);
  assign acc_wr = accept & write;
  assign acc_rd = accept & read & ~write;

  // FSM state and clear counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // Next-state logic: sweep the clear counter once, then park in READY.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_CLEAR: begin
        if (clken) begin
          if (clr_cnt == LAST_IDX) begin
            state_next = ST_READY;
          end else begin
            clr_cnt_next = clr_cnt + IDX_W'(1);
          end
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_READY;
      end
    endcase
  end

  // init_done registered alongside the state so it rises with READY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= (state_next == ST_READY);
    end
  end

  // RAM array: clear fill or byte-lane write; contents are never reset.
  always_ff @(posedge clk) begin
    if ((state == ST_CLEAR) && clken) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (acc_wr && in_range) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (byteenable[b]) begin
          mem[idx][b*8 +: 8] <= writedata[b*8 +: 8];
        end
      end
    end
  end

  // First read stage: captures the RAM word (or zero when out of range).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (clken) begin
      s1_valid <= acc_rd;
      if (acc_rd) begin
        s1_data <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_error <= 1'b0;
    end else if (accept && !in_range) begin
      oob_error <= 1'b1;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    // Extra output stage; data only advances with a valid word so it holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (clken) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign readdatavalid = s2_valid;
    assign readdata      = s2_data;
  end else begin : g_lat1
    assign readdatavalid = s1_valid;
    assign readdata      = s1_data;
  end

endmodule

// File: tb/tb_avalon_onchip_ram_ctrl.sv
// Bench for avalon_onchip_ram_ctrl: latency-1 and latency-2 instances share one stimulus.
module tb_avalon_onchip_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  addr;
  logic [3:0]  be;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [31:0] wd;
  logic        ce;

  logic [31:0] rdata1, rdata2;
  logic        rv1, rv2, wait1, wait2, init1, init2, oob1, oob2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_onchip_ram_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'hA5A5A5A5)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(addr), .byteenable(be),
    .chipselect(cs), .read(rd), .write(wr), .writedata(wd), .clken(ce),
    .readdata(rdata1), .readdatavalid(rv1), .waitrequest(wait1),
    .init_done(init1), .oob_error(oob1)
  );

  avalon_onchip_ram_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'hA5A5A5A5)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(addr), .byteenable(be),
    .chipselect(cs), .read(rd), .write(wr), .writedata(wd), .clken(ce),
    .readdata(rdata2), .readdatavalid(rv2), .waitrequest(wait2),
    .init_done(init2), .oob_error(oob2)
  );

  typedef struct {
    logic        cs, rd, wr, ce;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ew;
    logic        ev1;
    logic [31:0] ed1;
    logic        ev2;
    logic [31:0] ed2;
    logic        eoob;
  } vec_t;

  vec_t vt[40];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic r, input logic w, input logic e,
                     input logic [4:0] a, input logic [3:0] b, input logic [31:0] d,
                     input logic ew, input logic ev1, input logic [31:0] ed1,
                     input logic ev2, input logic [31:0] ed2, input logic eoob);
    vt[nv].cs = c;   vt[nv].rd = r;   vt[nv].wr = w;     vt[nv].ce = e;
    vt[nv].addr = a; vt[nv].be = b;   vt[nv].wd = d;     vt[nv].ew = ew;
    vt[nv].ev1 = ev1; vt[nv].ed1 = ed1; vt[nv].ev2 = ev2; vt[nv].ed2 = ed2;
    vt[nv].eoob = eoob;
    nv++;
  endtask

  task automatic idle();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; be = 4'hF; wd = '0; addr = '0; ce = 1'b1;
  endtask

  // Counts sampled cycles with waitrequest high until it drops (bounded).
  task automatic count_clear(output int n, output int early);
    n = 0;
    early = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!wait1) break;
      n++;
      if (init1 | init2) early++;
    end
  endtask

  // Single read, checking both latencies against an expected word.
  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk({nm, " lat1 valid"}, 32'(rv1), 32'd1);
    chk({nm, " lat1 data"}, rdata1, exp);
    chk({nm, " lat2 early"}, 32'(rv2), 32'd0);
    @(negedge clk);
    chk({nm, " lat2 valid"}, 32'(rv2), 32'd1);
    chk({nm, " lat2 data"}, rdata2, exp);
  endtask

  initial begin
    int n;
    int early;

    reset_n = 1'b0;
    idle();

    // Vector table: inputs for one cycle, outputs sampled before that cycle's edge.
    //   cs rd wr ce addr be     wdata         wait v1 d1            v2 d2            oob
    add(1, 1, 0, 1, 9,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 0, 1, 1, 3,  4'hF, 32'h11223344, 0, 1, 32'hA5A5A5A5, 0, 32'h0,        0);
    add(1, 0, 1, 1, 3,  4'h5, 32'hDEADBEEF, 0, 0, 32'h0,        1, 32'hA5A5A5A5, 0);
    add(1, 1, 0, 1, 3,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 0, 1, 1, 0,  4'hF, 32'h0,        0, 1, 32'h11AD33EF, 0, 32'h0,        0);
    add(1, 0, 1, 1, 1,  4'hF, 32'h1,        0, 0, 32'h0,        1, 32'h11AD33EF, 0);
    add(1, 0, 1, 1, 2,  4'hF, 32'h2,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 0, 1, 1, 3,  4'hF, 32'h3,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 1, 1,  4'hF, 32'h0,        0, 1, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 1, 2,  4'hF, 32'h0,        0, 1, 32'h1,        1, 32'h0,        0);
    add(1, 1, 0, 1, 3,  4'hF, 32'h0,        0, 1, 32'h2,        1, 32'h1,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 1, 32'h3,        1, 32'h2,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'h3,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 0, 1, 1, 5,  4'hF, 32'hCAFEF00D, 0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 1, 5,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 1, 1, 6,  4'hF, 32'h12345678, 0, 1, 32'hCAFEF00D, 0, 32'h0,        0);
    add(1, 1, 0, 1, 6,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'hCAFEF00D, 0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 1, 32'h12345678, 0, 32'h0,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'h12345678, 0);
    add(0, 1, 0, 1, 5,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    // clken stall of three cycles right after a read is accepted
    add(1, 1, 0, 1, 5,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 0, 6,  4'hF, 32'h0,        1, 1, 32'hCAFEF00D, 0, 32'h0,        0);
    add(1, 1, 0, 0, 6,  4'hF, 32'h0,        1, 1, 32'hCAFEF00D, 0, 32'h0,        0);
    add(1, 1, 0, 0, 6,  4'hF, 32'h0,        1, 1, 32'hCAFEF00D, 0, 32'h0,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 1, 32'hCAFEF00D, 0, 32'h0,        0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'hCAFEF00D, 0);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0);
    // out-of-range write/read, then a neighbour that would alias on truncation
    add(1, 0, 1, 1, 20, 4'hF, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 32'h0,        0);
    add(1, 1, 0, 1, 20, 4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1);
    add(1, 1, 0, 1, 4,  4'hF, 32'h0,        0, 1, 32'h0,        0, 32'h0,        1);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 1, 32'hA5A5A5A5, 1, 32'h0,        1);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'hA5A5A5A5, 1);
    add(0, 0, 0, 1, 0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0,        1);

    // Reset values while reset_n is held low
    #2;
    chk("reset readdata1", rdata1, 32'h0);
    chk("reset readdata2", rdata2, 32'h0);
    chk("reset valid1", 32'(rv1), 32'd0);
    chk("reset valid2", 32'(rv2), 32'd0);
    chk("reset wait1", 32'(wait1), 32'd1);
    chk("reset init1", 32'(init1), 32'd0);
    chk("reset oob1", 32'(oob1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    // A write held on the bus during the clear must be ignored.
    cs = 1'b1; wr = 1'b1; addr = 5'd9; wd = 32'h0;
    count_clear(n, early);
    idle();
    chk("clear1 wait cycles", 32'(n), 32'd16);
    chk("clear1 early init", 32'(early), 32'd0);
    chk("clear1 init1", 32'(init1), 32'd1);
    chk("clear1 init2", 32'(init2), 32'd1);
    chk("clear1 wait2", 32'(wait2), 32'd0);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk); #1;
      cs = vt[i].cs; rd = vt[i].rd; wr = vt[i].wr; ce = vt[i].ce;
      addr = vt[i].addr; be = vt[i].be; wd = vt[i].wd;
      @(negedge clk);
      chk($sformatf("row%0d wait1", i), 32'(wait1), 32'(vt[i].ew));
      chk($sformatf("row%0d wait2", i), 32'(wait2), 32'(vt[i].ew));
      chk($sformatf("row%0d valid1", i), 32'(rv1), 32'(vt[i].ev1));
      chk($sformatf("row%0d valid2", i), 32'(rv2), 32'(vt[i].ev2));
      if (vt[i].ev1) chk($sformatf("row%0d data1", i), rdata1, vt[i].ed1);
      if (vt[i].ev2) chk($sformatf("row%0d data2", i), rdata2, vt[i].ed2);
      chk($sformatf("row%0d oob1", i), 32'(oob1), 32'(vt[i].eoob));
      chk($sformatf("row%0d oob2", i), 32'(oob2), 32'(vt[i].eoob));
    end

    // readdata keeps the last returned word while readdatavalid is low
    chk("hold data1", rdata1, 32'hA5A5A5A5);
    chk("hold data2", rdata2, 32'hA5A5A5A5);

    // Asynchronous reset between clock edges
    @(posedge clk); #1;
    idle();
    reset_n = 1'b0;
    #1;
    chk("async readdata1", rdata1, 32'h0);
    chk("async readdata2", rdata2, 32'h0);
    chk("async init1", 32'(init1), 32'd0);
    chk("async wait1", 32'(wait1), 32'd1);
    chk("async oob1", 32'(oob1), 32'd0);
    chk("async oob2", 32'(oob2), 32'd0);

    // Release, let the clear reach counter 7, then reset mid-clear
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("midclear wait1", 32'(wait1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midclear rst wait1", 32'(wait1), 32'd1);
    chk("midclear rst init1", 32'(init1), 32'd0);
    chk("midclear rst init2", 32'(init2), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    count_clear(n, early);
    chk("clear2 wait cycles", 32'(n), 32'd16);
    chk("clear2 early init", 32'(early), 32'd0);
    chk("clear2 init1", 32'(init1), 32'd1);

    // Whole array refilled by the restarted clear
    rd_check(5'd5,  32'hA5A5A5A5, "refill a5");
    rd_check(5'd15, 32'hA5A5A5A5, "refill a15");
    rd_check(5'd3,  32'hA5A5A5A5, "refill a3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
